// File: rtl/hl_result_display.sv
// Decodes the game's 4-bit result code to 7-segment drive and tracks the pass streak, best streak and round count.
// Latency: 1 clk from value to seg. Backpressure: none; this block is a free-running sink that samples value every cycle.
module hl_result_display #(
    parameter int BLINK_TICKS = 5_000_000,
    parameter int BLINK_W     = 23,
    parameter int MAX_STREAK  = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] value,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] streak,
    output logic [3:0] best,
    output logic [7:0] rounds
);

    localparam logic [3:0]         CODE_PASS  = 4'd10;
    localparam logic [3:0]         CODE_FAIL  = 4'd11;
    localparam logic [3:0]         STREAK_MAX = 4'(MAX_STREAK);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

    typedef enum logic {
        BLINK_OFF = 1'b0,
        BLINK_ON  = 1'b1
    } blink_state_t;

    logic [3:0]         value_q, value_d;
    logic [3:0]         streak_q, streak_d;
    logic [3:0]         best_q, best_d;
    logic [7:0]         rounds_q, rounds_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    blink_state_t       blink_state_q, blink_state_d;

    logic       held_result;
    logic       pass_evt;
    logic       fail_evt;
    logic [3:0] streak_inc;
    logic [7:0] rounds_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q       <= 4'd0;
            streak_q      <= 4'd0;
            best_q        <= 4'd0;
            rounds_q      <= 8'd0;
            blink_cnt_q   <= '0;
            blink_state_q <= BLINK_ON;
        end else begin
            value_q       <= value_d;
            streak_q      <= streak_d;
            best_q        <= best_d;
            rounds_q      <= rounds_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_state_q <= blink_state_d;
        end
    end

    // A result only counts on entry from a non-result code, so a held or swapped 10/11 is scored once.
    always_comb begin
        held_result = (value_q == CODE_PASS) || (value_q == CODE_FAIL);
        pass_evt    = (value == CODE_PASS) && !held_result;
        fail_evt    = (value == CODE_FAIL) && !held_result;
        streak_inc  = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
        rounds_inc  = (rounds_q == 8'hFF) ? 8'hFF : rounds_q + 8'd1;

        value_d  = value;
        streak_d = streak_q;
        best_d   = best_q;
        rounds_d = rounds_q;
        if (pass_evt) begin
            streak_d = streak_inc;
            best_d   = (streak_inc > best_q) ? streak_inc : best_q;
            rounds_d = rounds_inc;
        end else if (fail_evt) begin
            streak_d = 4'd0;
            rounds_d = rounds_inc;
        end
    end

    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_state_d = blink_state_q;
        if ((value_q != CODE_FAIL) || fail_evt) begin
            blink_cnt_d   = '0;
            blink_state_d = BLINK_ON;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_state_d = (blink_state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
        end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end
    end

    always_comb begin
        seg = 7'h00;
        case (value_q)
            4'd0:  seg = 7'h3F;
            4'd1:  seg = 7'h06;
            4'd2:  seg = 7'h5B;
            4'd3:  seg = 7'h4F;
            4'd4:  seg = 7'h66;
            4'd5:  seg = 7'h6D;
            4'd6:  seg = 7'h7D;
            4'd7:  seg = 7'h07;
            4'd8:  seg = 7'h7F;
            4'd9:  seg = 7'h6F;
            4'd10: seg = 7'h73;
            4'd11: seg = (blink_state_q == BLINK_ON) ? 7'h71 : 7'h00;
            default: seg = 7'h00;
        endcase
    end

    assign dp     = (streak_q == best_q) && (best_q != 4'd0);
    assign streak = streak_q;
    assign best   = best_q;
    assign rounds = rounds_q;

endmodule

// File: tb/tb_hl_result_display.sv
// Bench for hl_result_display with a short blink period: vector table, saturation sequences and randomized runs.
module tb_hl_result_display;

    localparam int TICKS = 4;
    localparam int SMAX  = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] value;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] streak;
    logic [3:0] best;
    logic [7:0] rounds;

    hl_result_display #(
        .BLINK_TICKS(TICKS),
        .BLINK_W    (2),
        .MAX_STREAK (SMAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .seg   (seg),
        .dp    (dp),
        .streak(streak),
        .best  (best),
        .rounds(rounds)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] v;
        logic       rst;
        logic [6:0] seg;
        logic [3:0] stk;
        logic [3:0] bst;
        logic [7:0] rnd;
        logic       dp;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad   = 0;

    logic [6:0] digit_seg [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                   7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference model state: last sampled code, counters, and cycles the fail glyph has been shown.
    int m_vq, m_stk, m_bst, m_rnd, m_age;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_seg();
        if (m_vq < 10) return int'(digit_seg[m_vq]);
        if (m_vq == 10) return 'h73;
        if (m_vq == 11) return (((m_age / TICKS) % 2) == 0) ? 'h71 : 'h00;
        return 0;
    endfunction

    task automatic model_edge(input int v, input bit r);
        bit scored_before;
        if (r) begin
            m_vq = 0; m_stk = 0; m_bst = 0; m_rnd = 0; m_age = 0;
        end else begin
            scored_before = (m_vq == 10) || (m_vq == 11);
            if (v == 10 && !scored_before) begin
                m_stk = (m_stk + 1 > SMAX) ? SMAX : m_stk + 1;
                m_bst = (m_stk > m_bst) ? m_stk : m_bst;
                m_rnd = (m_rnd + 1 > 255) ? 255 : m_rnd + 1;
            end else if (v == 11 && !scored_before) begin
                m_stk = 0;
                m_rnd = (m_rnd + 1 > 255) ? 255 : m_rnd + 1;
            end
            m_age = (v == 11 && m_vq == 11) ? m_age + 1 : 0;
            m_vq  = v;
        end
    endtask

    task automatic step(input logic [3:0] v, input logic r);
        @(negedge clk);
        value = v;
        reset = r;
        @(posedge clk);
        model_edge(int'(v), r);
        #1;
        chk("mdl_seg", int'(seg), model_seg());
        chk("mdl_streak", int'(streak), m_stk);
        chk("mdl_best", int'(best), m_bst);
        chk("mdl_rounds", int'(rounds), m_rnd);
        chk("mdl_dp", int'(dp), int'((m_stk == m_bst) && (m_bst != 0)));
    endtask

    task automatic addv(input logic [3:0] v, input logic r, input logic [6:0] s,
                        input logic [3:0] k, input logic [3:0] b, input logic [7:0] n,
                        input logic d);
        vec_t t;
        t.v = v; t.rst = r; t.seg = s; t.stk = k; t.bst = b; t.rnd = n; t.dp = d;
        vecs.push_back(t);
    endtask

    initial begin
        int len;
        logic [3:0] rv;
        reset = 1'b1;
        value = 4'd0;

        addv(4'd7, 0, 7'h07, 0, 0, 0, 0);
        addv(4'd5, 0, 7'h6D, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) addv(4'd10, 0, 7'h73, 1, 1, 1, 1);
        addv(4'd5, 0, 7'h6D, 1, 1, 1, 1);
        for (int i = 0; i < 3; i++) addv(4'd10, 0, 7'h73, 2, 2, 2, 1);
        addv(4'd5, 0, 7'h6D, 2, 2, 2, 1);
        for (int i = 0; i < 12; i++)
            addv(4'd11, 0, ((i / 4) == 1) ? 7'h00 : 7'h71, 0, 2, 3, 0);
        addv(4'd3, 0, 7'h4F, 0, 2, 3, 0);
        addv(4'd10, 0, 7'h73, 1, 2, 4, 0);
        addv(4'd11, 0, 7'h71, 1, 2, 4, 0);
        addv(4'd3, 0, 7'h4F, 1, 2, 4, 0);
        addv(4'd13, 0, 7'h00, 1, 2, 4, 0);
        for (int i = 0; i < 4; i++) addv(4'd11, 0, 7'h71, 0, 2, 5, 0);
        addv(4'd11, 0, 7'h00, 0, 2, 5, 0);
        addv(4'd11, 1, 7'h3F, 0, 0, 0, 0);
        addv(4'd11, 0, 7'h71, 0, 0, 1, 0);
        addv(4'd11, 0, 7'h71, 0, 0, 1, 0);

        step(4'd0, 1'b1);
        chk("rst_seg", int'(seg), 'h3F);
        chk("rst_dp", int'(dp), 0);
        chk("rst_streak", int'(streak), 0);
        chk("rst_best", int'(best), 0);
        chk("rst_rounds", int'(rounds), 0);

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].rst);
            chk($sformatf("vec%0d_seg", i), int'(seg), int'(vecs[i].seg));
            chk($sformatf("vec%0d_streak", i), int'(streak), int'(vecs[i].stk));
            chk($sformatf("vec%0d_best", i), int'(best), int'(vecs[i].bst));
            chk($sformatf("vec%0d_rounds", i), int'(rounds), int'(vecs[i].rnd));
            chk($sformatf("vec%0d_dp", i), int'(dp), int'(vecs[i].dp));
        end

        step(4'd0, 1'b1);
        for (int i = 0; i < 11; i++) begin
            step(4'd10, 1'b0);
            step(4'd1, 1'b0);
        end
        chk("sat_streak", int'(streak), 9);
        chk("sat_best", int'(best), 9);
        chk("sat_rounds11", int'(rounds), 11);
        chk("sat_dp", int'(dp), 1);
        for (int i = 0; i < 300; i++) begin
            step((i % 2) ? 4'd10 : 4'd11, 1'b0);
            step(4'd2, 1'b0);
        end
        chk("sat_rounds255", int'(rounds), 255);
        step(4'd11, 1'b0);
        chk("sat_rounds_hold", int'(rounds), 255);
        chk("sat_best_hold", int'(best), 9);

        for (int run = 0; run < 300; run++) begin
            if ($urandom_range(0, 3) < 2) rv = 4'(10 + $urandom_range(0, 1));
            else rv = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 10);
            for (int k = 0; k < len; k++)
                step(rv, ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
